// File: rtl/cic_agc_pkg.sv
// Shared types and helpers for the CIC automatic gain controller.
// State encodings are fixed because agc_state is exported for debug.
package cic_agc_pkg;

    typedef enum logic [1:0] {
        ST_MEASURE = 2'd0,
        ST_DECIDE  = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_MANUAL  = 2'd3
    } agc_state_t;

    localparam int CLIP_STEP = 2;

    // Gain arithmetic happens in int so that steps below GAIN_MIN or above GAIN_MAX
    // saturate at the limit instead of wrapping.
    function automatic int clamp_int(input int value, input int lo, input int hi);
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/cic_peak_detect.sv
// Sample magnitude, full-scale detection and the running peak register for the AGC.
// clip_seen records a full-scale sample among the accumulated samples of the current window.
module cic_peak_detect #(
    parameter int BITS = 16
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic signed [BITS-1:0] x_in,
    input  logic                   in_tick,
    input  logic                   accumulate,
    input  logic                   clear,
    output logic        [BITS-2:0] peak,
    output logic                   clip_seen,
    output logic                   full_scale
);

    localparam logic signed [BITS-1:0] POS_FS = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0] NEG_FS = {1'b1, {(BITS-1){1'b0}}};

    logic signed [BITS-1:0] neg_x;
    logic        [BITS-2:0] mag;
    logic                   take;

    assign neg_x = -x_in;

    // The most negative code has no positive twin, so it saturates to the largest magnitude.
    always_comb begin
        mag = x_in[BITS-2:0];
        if (x_in == NEG_FS)
            mag = '1;
        else if (x_in[BITS-1])
            mag = neg_x[BITS-2:0];
    end

    assign full_scale = in_tick && ((x_in == POS_FS) || (x_in == NEG_FS));
    assign take       = accumulate && in_tick;

    // A clear can coincide with an accepted sample; that sample seeds the new window.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            peak      <= '0;
            clip_seen <= 1'b0;
        end else if (clear) begin
            peak      <= take ? mag : '0;
            clip_seen <= take && full_scale;
        end else if (take) begin
            if (mag > peak)
                peak <= mag;
            if (full_scale)
                clip_seen <= 1'b1;
        end
    end

endmodule

// File: rtl/cic_agc.sv
// Automatic gain controller for the CIC decimator: windowed peak measurement,
// hysteretic gain stepping with a settling hold-off, and a manual override.
module cic_agc
    import cic_agc_pkg::*;
#(
    parameter int BITS        = 16,
    parameter int GAIN_BITS   = 8,
    parameter int WIN_LEN     = 64,
    parameter int HIGH_THRESH = 16384,
    parameter int LOW_THRESH  = 4096,
    parameter int GAIN_MIN    = 0,
    parameter int GAIN_MAX    = 31,
    parameter int GAIN_INIT   = 16,
    parameter int HOLDOFF     = 8
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic signed [BITS-1:0] x_in,
    input  logic                   in_tick,
    input  logic                   manual_en,
    input  logic [GAIN_BITS-1:0]   manual_gain,
    input  logic                   clip_clr,
    output logic [GAIN_BITS-1:0]   gain,
    output logic                   gain_changed,
    output logic                   clip,
    output logic [1:0]             agc_state
);

    localparam int WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [BITS-2:0]   HIGH_T    = (BITS-1)'(HIGH_THRESH);
    localparam logic [BITS-2:0]   LOW_T     = (BITS-1)'(LOW_THRESH);

    agc_state_t state, state_next;

    logic [WIN_W-1:0]     win_cnt, win_cnt_next;
    logic [HOLD_W-1:0]    hold_cnt, hold_cnt_next;
    logic [GAIN_BITS-1:0] gain_next, gain_dec, gain_man;
    logic [BITS-2:0]      peak;
    logic                 clip_seen, full_scale;
    logic                 peak_acc, peak_clear;

    cic_peak_detect #(
        .BITS(BITS)
    ) u_peak (
        .CLK        (CLK),
        .RSTb       (RSTb),
        .x_in       (x_in),
        .in_tick    (in_tick),
        .accumulate (peak_acc),
        .clear      (peak_clear),
        .peak       (peak),
        .clip_seen  (clip_seen),
        .full_scale (full_scale)
    );

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb)
            state <= ST_MEASURE;
        else
            state <= state_next;
    end

    // Window decision and manual target, both saturating.
    always_comb begin
        gain_dec = gain;
        if (clip_seen)
            gain_dec = GAIN_BITS'(clamp_int(int'(gain) - CLIP_STEP, GAIN_MIN, GAIN_MAX));
        else if (peak >= HIGH_T)
            gain_dec = GAIN_BITS'(clamp_int(int'(gain) - 1, GAIN_MIN, GAIN_MAX));
        else if (peak < LOW_T)
            gain_dec = GAIN_BITS'(clamp_int(int'(gain) + 1, GAIN_MIN, GAIN_MAX));
        gain_man = GAIN_BITS'(clamp_int(int'(manual_gain), GAIN_MIN, GAIN_MAX));
    end

    always_comb begin
        state_next = state;
        if (manual_en) begin
            state_next = ST_MANUAL;
        end else begin
            case (state)
                ST_MEASURE: if (in_tick && (win_cnt == WIN_LAST)) state_next = ST_DECIDE;
                ST_DECIDE:  state_next = (gain_dec != gain) ? ST_HOLDOFF : ST_MEASURE;
                ST_HOLDOFF: if (in_tick && (hold_cnt >= HOLD_LAST)) state_next = ST_MEASURE;
                ST_MANUAL:  state_next = ST_HOLDOFF;
                default:    state_next = ST_MEASURE;
            endcase
        end
    end

    // A tick landing in DECIDE is credited to whichever state follows.
    always_comb begin
        gain_next     = gain;
        win_cnt_next  = '0;
        hold_cnt_next = '0;
        peak_acc      = 1'b0;
        peak_clear    = 1'b0;
        if (manual_en) begin
            gain_next  = gain_man;
            peak_clear = 1'b1;
        end else begin
            case (state)
                ST_MEASURE: begin
                    peak_acc     = 1'b1;
                    win_cnt_next = win_cnt;
                    if (in_tick)
                        win_cnt_next = (win_cnt == WIN_LAST) ? '0 : win_cnt + WIN_W'(1);
                end
                ST_DECIDE: begin
                    gain_next  = gain_dec;
                    peak_clear = 1'b1;
                    peak_acc   = (state_next == ST_MEASURE);
                    if (in_tick && (state_next == ST_MEASURE))
                        win_cnt_next = WIN_W'(1);
                    if (in_tick && (state_next == ST_HOLDOFF))
                        hold_cnt_next = HOLD_W'(1);
                end
                ST_HOLDOFF: begin
                    hold_cnt_next = hold_cnt;
                    if (in_tick)
                        hold_cnt_next = (hold_cnt >= HOLD_LAST) ? '0 : hold_cnt + HOLD_W'(1);
                end
                default: begin
                    peak_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            gain         <= GAIN_BITS'(GAIN_INIT);
            gain_changed <= 1'b0;
            clip         <= 1'b0;
            win_cnt      <= '0;
            hold_cnt     <= '0;
        end else begin
            gain         <= gain_next;
            gain_changed <= (gain_next != gain);
            win_cnt      <= win_cnt_next;
            hold_cnt     <= hold_cnt_next;
            if (full_scale)
                clip <= 1'b1;
            else if (clip_clr)
                clip <= 1'b0;
        end
    end

    assign agc_state = state;

endmodule

// File: tb/tb_cic_agc.sv
// Directed bench for cic_agc: windows of hand-chosen samples with hand-computed gain steps.
module tb_cic_agc;

    logic               CLK;
    logic               RSTb;
    logic signed [15:0] x_in;
    logic               in_tick;
    logic               manual_en;
    logic [7:0]         manual_gain;
    logic               clip_clr;
    logic [7:0]         gain;
    logic               gain_changed;
    logic               clip;
    logic [1:0]         agc_state;

    int checks = 0;
    int errors = 0;

    localparam int S_MEASURE = 0;
    localparam int S_DECIDE  = 1;
    localparam int S_HOLDOFF = 2;
    localparam int S_MANUAL  = 3;

    cic_agc dut (
        .CLK          (CLK),
        .RSTb         (RSTb),
        .x_in         (x_in),
        .in_tick      (in_tick),
        .manual_en    (manual_en),
        .manual_gain  (manual_gain),
        .clip_clr     (clip_clr),
        .gain         (gain),
        .gain_changed (gain_changed),
        .clip         (clip),
        .agc_state    (agc_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input logic signed [15:0] v);
        @(negedge CLK);
        x_in    = v;
        in_tick = 1'b1;
        @(negedge CLK);
        in_tick = 1'b0;
    endtask

    // 64 ticks alternating +/-base, with one special sample at loud_idx.
    task automatic run_window(input int loud_idx, input logic signed [15:0] loud_val,
                              input logic signed [15:0] base);
        for (int i = 0; i < 64; i++) begin
            if (i == loud_idx)
                tick(loud_val);
            else if (i % 2 == 1)
                tick(-base);
            else
                tick(base);
            if (i == 62)
                check("win_not_done", int'(agc_state), S_MEASURE);
        end
        check("win_end_decide", int'(agc_state), S_DECIDE);
    endtask

    task automatic check_decide(input string tag, input int exp_gain, input int exp_pulse,
                                input int exp_state);
        @(negedge CLK);
        check({tag, "_gain"}, int'(gain), exp_gain);
        check({tag, "_pulse"}, int'(gain_changed), exp_pulse);
        check({tag, "_state"}, int'(agc_state), exp_state);
    endtask

    task automatic run_holdoff(input int n, input logic signed [15:0] v);
        for (int i = 0; i < n; i++) begin
            tick(v);
            if (i == n - 2)
                check("holdoff_busy", int'(agc_state), S_HOLDOFF);
        end
        check("holdoff_done", int'(agc_state), S_MEASURE);
    endtask

    initial begin
        RSTb        = 1'b0;
        x_in        = '0;
        in_tick     = 1'b0;
        manual_en   = 1'b0;
        manual_gain = '0;
        clip_clr    = 1'b0;

        repeat (2) @(negedge CLK);
        check("rst_gain", int'(gain), 16);
        check("rst_pulse", int'(gain_changed), 0);
        check("rst_clip", int'(clip), 0);
        check("rst_state", int'(agc_state), S_MEASURE);
        RSTb = 1'b1;

        // Mid-range window: no change.
        run_window(-1, 16'sd0, 16'sd8000);
        check_decide("mid", 16, 0, S_MEASURE);

        // Quiet windows walk the gain up to the ceiling; holdoff ticks are loud but ignored.
        for (int g = 16; g < 31; g++) begin
            run_window(-1, 16'sd0, 16'sd1000);
            check_decide("quiet", g + 1, 1, S_HOLDOFF);
            if (g == 16) begin
                @(negedge CLK);
                check("pulse_one_cycle", int'(gain_changed), 0);
            end
            run_holdoff(8, -16'sd20000);
        end
        run_window(-1, 16'sd0, 16'sd1000);
        check_decide("quiet_at_max", 31, 0, S_MEASURE);

        // Loud windows and threshold boundaries.
        @(negedge CLK);
        RSTb = 1'b0;
        @(negedge CLK);
        RSTb = 1'b1;
        check("rst2_gain", int'(gain), 16);
        run_window(5, -16'sd20000, 16'sd1000);
        check_decide("loud", 15, 1, S_HOLDOFF);
        run_holdoff(8, 16'sd1000);
        run_window(9, 16'sd16384, 16'sd1000);
        check_decide("peak_high_edge", 14, 1, S_HOLDOFF);
        run_holdoff(8, 16'sd1000);
        run_window(10, 16'sd4096, 16'sd4000);
        check_decide("peak_low_edge", 14, 0, S_MEASURE);

        // Pin gain to 1 through manual mode, then clip drives it to 0.
        @(negedge CLK);
        manual_en   = 1'b1;
        manual_gain = 8'd1;
        @(negedge CLK);
        check("man1_gain", int'(gain), 1);
        check("man1_pulse", int'(gain_changed), 1);
        check("man1_state", int'(agc_state), S_MANUAL);
        manual_en = 1'b0;
        @(negedge CLK);
        check("man1_exit_state", int'(agc_state), S_HOLDOFF);
        check("man1_exit_gain", int'(gain), 1);
        run_holdoff(8, 16'sd1000);
        run_window(20, -16'sd32768, 16'sd8000);
        check("clip_set", int'(clip), 1);
        check_decide("clip", 0, 1, S_HOLDOFF);

        @(negedge CLK);
        x_in     = 16'sd32767;
        in_tick  = 1'b1;
        clip_clr = 1'b1;
        @(negedge CLK);
        in_tick  = 1'b0;
        clip_clr = 1'b0;
        check("clip_set_wins", int'(clip), 1);
        clip_clr = 1'b1;
        @(negedge CLK);
        clip_clr = 1'b0;
        check("clip_cleared", int'(clip), 0);
        run_holdoff(7, 16'sd1000);

        // Manual override with out-of-range request, then retarget.
        @(negedge CLK);
        manual_en   = 1'b1;
        manual_gain = 8'd200;
        @(negedge CLK);
        check("man200_gain", int'(gain), 31);
        check("man200_pulse", int'(gain_changed), 1);
        check("man200_state", int'(agc_state), S_MANUAL);
        @(negedge CLK);
        check("man200_hold_pulse", int'(gain_changed), 0);
        manual_gain = 8'd5;
        @(negedge CLK);
        check("man5_gain", int'(gain), 5);
        check("man5_pulse", int'(gain_changed), 1);
        manual_en = 1'b0;
        @(negedge CLK);
        check("man_exit_state", int'(agc_state), S_HOLDOFF);
        check("man_exit_gain", int'(gain), 5);
        check("man_exit_pulse", int'(gain_changed), 0);
        run_holdoff(8, -16'sd20000);
        run_window(-1, 16'sd0, 16'sd1000);
        check_decide("after_manual", 6, 1, S_HOLDOFF);
        run_holdoff(8, 16'sd1000);

        // Asynchronous reset partway through a loud window.
        for (int i = 0; i < 30; i++)
            tick(-16'sd20000);
        #2 RSTb = 1'b0;
        #1;
        check("async_rst_gain", int'(gain), 16);
        check("async_rst_state", int'(agc_state), S_MEASURE);
        check("async_rst_wincnt", int'(dut.win_cnt), 0);
        @(negedge CLK);
        RSTb = 1'b1;
        run_window(0, -16'sd20000, 16'sd1000);
        check_decide("post_rst", 15, 1, S_HOLDOFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
